sram_port_arbiter: RTL and testbench

Shares one SRAM-like memory port between the fetch stage (inst side) and the MEM stage (data side).
- Arbitration uses fixed data priority with an anti-starvation streak limit.
- Owner is held while a request is waiting for addr_ok.
- Each accepted transaction is tagged in an in-order ID FIFO so that data_ok and rdata are routed back to the issuing side.
- Sits between the pipeline front/MEM stages and the AXI bridge.

---
 rtl/sram_port_arbiter_pkg.sv | 9 +
 rtl/sram_port_arbiter_tag_fifo.sv | 38 +++
 rtl/sram_port_arbiter.sv | 123 ++++++++++++
 tb/tb_sram_port_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// Shared constants for the inst/data SRAM port arbiter: response tags and size encodings.
package sram_port_arbiter_pkg;
  localparam logic TAG_INST = 1'b0;
  localparam logic TAG_DATA = 1'b1;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
endpackage

// File: rtl/sram_port_arbiter_tag_fifo.sv
// In-order 1-bit tag FIFO recording which side issued each accepted transaction.
module tag_fifo #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        din,
  input  logic        pop,
  output logic        dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);
  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr, rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like port between fetch (inst) and MEM (data) with data priority,
// an anti-starvation streak limit, owner lock during stalls and in-order response routing.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int OUTSTANDING_DEPTH = 4,
  parameter int MAX_DATA_STREAK   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        protocol_err,
  output logic        idle
);
  localparam int AW = $clog2(OUTSTANDING_DEPTH);
  localparam int SW = $clog2(MAX_DATA_STREAK + 1);

  logic          locked, lock_owner, owner, owner_req, accept, pop;
  logic          full, empty, head_tag, err_q;
  logic [AW:0]   count;
  logic [SW-1:0] streak;

  // Data wins unless it has starved a waiting fetch for MAX_DATA_STREAK grants.
  always_comb begin
    owner = TAG_INST;
    if (locked)
      owner = lock_owner;
    else if (data_req && !((streak >= SW'(MAX_DATA_STREAK)) && inst_req))
      owner = TAG_DATA;
  end

  assign owner_req = (owner == TAG_DATA) ? data_req : inst_req;
  assign mem_req   = owner_req & ~full & ~rst;
  assign accept    = mem_req & mem_addr_ok;

  always_comb begin
    mem_wr    = 1'b0;
    mem_size  = '0;
    mem_wstrb = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst) begin
      if (owner == TAG_DATA) begin
        mem_wr = data_wr; mem_size = data_size; mem_wstrb = data_wstrb;
        mem_addr = data_addr; mem_wdata = data_wdata;
      end else begin
        mem_wr = inst_wr; mem_size = inst_size; mem_wstrb = inst_wstrb;
        mem_addr = inst_addr; mem_wdata = inst_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      locked     <= 1'b0;
      lock_owner <= TAG_INST;
      streak     <= '0;
      err_q      <= 1'b0;
    end else begin
      if (accept)
        locked <= 1'b0;
      else if (mem_req) begin
        locked     <= 1'b1;
        lock_owner <= owner;
      end

      if (!inst_req || (accept && owner == TAG_INST))
        streak <= '0;
      else if (accept && streak < SW'(MAX_DATA_STREAK))
        streak <= streak + 1'b1;

      if (mem_data_ok && empty) err_q <= 1'b1;
    end
  end

  tag_fifo #(.DEPTH(OUTSTANDING_DEPTH)) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .din   (owner),
    .pop   (pop),
    .dout  (head_tag),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign pop          = mem_data_ok & ~empty & ~rst;
  assign inst_addr_ok = accept & (owner == TAG_INST);
  assign data_addr_ok = accept & (owner == TAG_DATA);
  assign inst_data_ok = pop & (head_tag == TAG_INST);
  assign data_data_ok = pop & (head_tag == TAG_DATA);
  assign inst_rdata   = rst ? '0 : mem_rdata;
  assign data_rdata   = rst ? '0 : mem_rdata;
  assign protocol_err = err_q & ~rst;
  assign idle         = ~rst & (count == '0) & ~inst_req & ~data_req;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed self-checking bench for sram_port_arbiter (depth 4, streak limit 4).
module tb_sram_port_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req = 0, inst_wr = 0, data_req = 0, data_wr = 0;
  logic [1:0]  inst_size = 2'd2, data_size = 2'd2;
  logic [3:0]  inst_wstrb = 0, data_wstrb = 0;
  logic [31:0] inst_addr = 0, inst_wdata = 0, data_addr = 0, data_wdata = 0;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok = 0, mem_data_ok = 0;
  logic [31:0] mem_rdata = 0;
  logic        protocol_err, idle;
  int          tests = 0, failed = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.OUTSTANDING_DEPTH(4), .MAX_DATA_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .protocol_err(protocol_err), .idle(idle)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1; inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'h1234;
    data_addr = 32'h55; #1;
    tests++; if (mem_req !== 0) begin failed++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
    tests++; if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b0) begin failed++; $display("FAIL reset_oks got %b exp 0000", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); end
    tests++; if ({mem_addr, data_rdata, protocol_err, idle} !== '0) begin failed++; $display("FAIL reset_outs got %h/%h/%b/%b exp 0", mem_addr, data_rdata, protocol_err, idle); end
    tick;
    tick;
    inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
    tick;
    rst = 0; #1;
    tests++; if (idle !== 1) begin failed++; $display("FAIL reset_idle got %b exp 1", idle); end
  endtask

  task automatic test_single_read;
    data_req = 1; data_addr = 32'h1c000100; data_wr = 0; data_size = 2'd2; #1;
    tests++; if (mem_req !== 1 || mem_addr !== 32'h1c000100) begin failed++; $display("FAIL single_req got %b %h exp 1 1c000100", mem_req, mem_addr); end
    tests++; if (data_addr_ok !== 0) begin failed++; $display("FAIL single_no_early_ok got %b exp 0", data_addr_ok); end
    tick; mem_addr_ok = 1; #1;
    tests++; if (data_addr_ok !== 1 || inst_addr_ok !== 0) begin failed++; $display("FAIL single_addr_ok got d%b i%b exp d1 i0", data_addr_ok, inst_addr_ok); end
    tick; data_req = 0; mem_addr_ok = 0; #1;
    tests++; if (data_addr_ok !== 0 || idle !== 0) begin failed++; $display("FAIL single_pending got ok%b idle%b exp 0 0", data_addr_ok, idle); end
    tick; mem_data_ok = 1; mem_rdata = 32'hdeadbeef; #1;
    tests++; if (data_data_ok !== 1 || data_rdata !== 32'hdeadbeef || inst_data_ok !== 0) begin failed++; $display("FAIL single_resp got d%b %h i%b exp d1 deadbeef i0", data_data_ok, data_rdata, inst_data_ok); end
    tick; mem_data_ok = 0; #1;
    tests++; if (idle !== 1 || data_data_ok !== 0) begin failed++; $display("FAIL single_idle got idle%b ok%b exp 1 0", idle, data_data_ok); end
  endtask

  task automatic test_streak;
    logic [9:0] exp_d;
    exp_d = 10'b0111101111;  // bit k = data grant on cycle k: D,D,D,D,I,D,D,D,D,I
    inst_req = 1; data_req = 1; mem_addr_ok = 1;
    for (int k = 0; k < 10; k++) begin
      mem_data_ok = (k > 0); #1;
      tests++; if (data_addr_ok !== exp_d[k] || inst_addr_ok !== !exp_d[k]) begin failed++; $display("FAIL streak_grant%0d got d%b i%b exp d%b", k, data_addr_ok, inst_addr_ok, exp_d[k]); end
      if (k > 0) begin
        tests++; if (data_data_ok !== exp_d[k-1] || inst_data_ok !== !exp_d[k-1]) begin failed++; $display("FAIL streak_resp%0d got d%b i%b exp d%b", k, data_data_ok, inst_data_ok, exp_d[k-1]); end
      end
      tick;
    end
    inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 1; #1;
    tests++; if (inst_data_ok !== 1) begin failed++; $display("FAIL streak_last_resp got %b exp 1", inst_data_ok); end
    tick; mem_data_ok = 0; #1;
    tests++; if (idle !== 1) begin failed++; $display("FAIL streak_idle got %b exp 1", idle); end
  endtask

  task automatic test_lock;
    // Inst owns a stalled port; data rising must not steal it.
    inst_req = 1; inst_addr = 32'h100; #1;
    tick; data_req = 1; data_addr = 32'h200; #1;
    tests++; if (mem_addr !== 32'h100) begin failed++; $display("FAIL lock_inst_addr got %h exp 00000100", mem_addr); end
    tick; mem_addr_ok = 1; #1;
    tests++; if (inst_addr_ok !== 1 || data_addr_ok !== 0) begin failed++; $display("FAIL lock_inst_accept got i%b d%b exp i1 d0", inst_addr_ok, data_addr_ok); end
    tick; inst_req = 0; mem_addr_ok = 0; #1;
    // Data stalls 3 cycles while inst rises.
    for (int k = 0; k < 3; k++) begin
      tests++; if (mem_addr !== 32'h200 || data_addr_ok !== 0 || inst_addr_ok !== 0) begin failed++; $display("FAIL lock_data_hold%0d got %h d%b i%b exp 00000200 0 0", k, mem_addr, data_addr_ok, inst_addr_ok); end
      tick; inst_req = 1; inst_addr = 32'h300; #1;
    end
    mem_addr_ok = 1; #1;
    tests++; if (data_addr_ok !== 1 || mem_addr !== 32'h200) begin failed++; $display("FAIL lock_data_accept got %b %h exp 1 00000200", data_addr_ok, mem_addr); end
    tick; data_req = 0; #1;
    tests++; if (inst_addr_ok !== 1 || mem_addr !== 32'h300) begin failed++; $display("FAIL lock_inst_next got %b %h exp 1 00000300", inst_addr_ok, mem_addr); end
    tick; inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; #1;
    tests++; if (inst_data_ok !== 1) begin failed++; $display("FAIL lock_resp0 got %b exp 1", inst_data_ok); end
    tick; #1;
    tests++; if (data_data_ok !== 1) begin failed++; $display("FAIL lock_resp1 got %b exp 1", data_data_ok); end
    tick; #1;
    tests++; if (inst_data_ok !== 1) begin failed++; $display("FAIL lock_resp2 got %b exp 1", inst_data_ok); end
    tick; mem_data_ok = 0;
  endtask

  task automatic test_full;
    data_req = 1; data_addr = 32'h400; mem_addr_ok = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      tests++; if (data_addr_ok !== 1) begin failed++; $display("FAIL full_fill%0d got %b exp 1", k, data_addr_ok); end
      tick;
    end
    #1;
    tests++; if (mem_req !== 0 || data_addr_ok !== 0) begin failed++; $display("FAIL full_block got req%b ok%b exp 0 0", mem_req, data_addr_ok); end
    tick; mem_data_ok = 1; #1;
    tests++; if (mem_req !== 0 || data_addr_ok !== 0 || data_data_ok !== 1) begin failed++; $display("FAIL full_pop_same got req%b ok%b dok%b exp 0 0 1", mem_req, data_addr_ok, data_data_ok); end
    tick; mem_data_ok = 0; #1;
    tests++; if (data_addr_ok !== 1) begin failed++; $display("FAIL full_after_pop got %b exp 1", data_addr_ok); end
    tick; data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      tests++; if (data_data_ok !== 1) begin failed++; $display("FAIL full_drain%0d got %b exp 1", k, data_data_ok); end
      tick;
    end
    mem_data_ok = 0; #1;
    tests++; if (idle !== 1) begin failed++; $display("FAIL full_idle got %b exp 1", idle); end
  endtask

  task automatic test_interleave;
    mem_addr_ok = 1; inst_req = 1; #1;
    tests++; if (inst_addr_ok !== 1) begin failed++; $display("FAIL il_issue0 got %b exp 1", inst_addr_ok); end
    tick; inst_req = 0; data_req = 1; #1;
    tests++; if (data_addr_ok !== 1) begin failed++; $display("FAIL il_issue1 got %b exp 1", data_addr_ok); end
    tick; data_req = 0; inst_req = 1; #1;
    tests++; if (inst_addr_ok !== 1) begin failed++; $display("FAIL il_issue2 got %b exp 1", inst_addr_ok); end
    tick; inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'd1; #1;
    tests++; if (inst_data_ok !== 1 || data_data_ok !== 0 || inst_rdata !== 32'd1) begin failed++; $display("FAIL il_resp0 got i%b d%b %h exp i1 d0 1", inst_data_ok, data_data_ok, inst_rdata); end
    tick; mem_rdata = 32'd2; #1;
    tests++; if (data_data_ok !== 1 || inst_data_ok !== 0 || data_rdata !== 32'd2) begin failed++; $display("FAIL il_resp1 got d%b i%b %h exp d1 i0 2", data_data_ok, inst_data_ok, data_rdata); end
    tick; mem_rdata = 32'd3; #1;
    tests++; if (inst_data_ok !== 1 || data_data_ok !== 0 || inst_rdata !== 32'd3) begin failed++; $display("FAIL il_resp2 got i%b d%b %h exp i1 d0 3", inst_data_ok, data_data_ok, inst_rdata); end
    tick; mem_data_ok = 0;
  endtask

  task automatic test_protocol_err;
    mem_data_ok = 1; #1;
    tests++; if (inst_data_ok !== 0 || data_data_ok !== 0 || protocol_err !== 0) begin failed++; $display("FAIL perr_spurious got i%b d%b e%b exp 0 0 0", inst_data_ok, data_data_ok, protocol_err); end
    tick; mem_data_ok = 0; #1;
    tests++; if (protocol_err !== 1) begin failed++; $display("FAIL perr_set got %b exp 1", protocol_err); end
    data_req = 1; mem_addr_ok = 1;
    tick; tick; data_req = 0; mem_addr_ok = 0; #1;
    tests++; if (protocol_err !== 1 || idle !== 0) begin failed++; $display("FAIL perr_held got e%b idle%b exp 1 0", protocol_err, idle); end
    rst = 1; #1;
    tests++; if (protocol_err !== 0 || mem_req !== 0) begin failed++; $display("FAIL perr_in_rst got e%b req%b exp 0 0", protocol_err, mem_req); end
    tick; rst = 0; #1;
    tests++; if (protocol_err !== 0 || idle !== 1) begin failed++; $display("FAIL perr_after_rst got e%b idle%b exp 0 1", protocol_err, idle); end
    mem_data_ok = 1; #1;
    tests++; if (data_data_ok !== 0 || inst_data_ok !== 0) begin failed++; $display("FAIL perr_no_stale got d%b i%b exp 0 0", data_data_ok, inst_data_ok); end
    tick; mem_data_ok = 0; #1;
    tests++; if (protocol_err !== 1) begin failed++; $display("FAIL perr_reset_count got %b exp 1", protocol_err); end
  endtask

  initial begin
    test_reset;
    tick; test_single_read;
    tick; test_streak;
    tick; test_lock;
    tick; test_full;
    tick; test_interleave;
    tick; test_protocol_err;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
